// File: rtl/timer_counter_if.sv
// Bridge-side bus bundle for the timer/counter: word-select register access
// plus the interrupt request toward CP0.
`timescale 1ns/1ps

interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface : timer_counter_if

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL (EN/MODE/IM), PRESET (r/w), COUNT (read-only); irq = IM & flag.
`timescale 1ns/1ps

module timer_counter #(
  parameter int CTRL_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  timer_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    A_CTRL   = 2'd0,
    A_PRESET = 2'd1,
    A_COUNT  = 2'd2,
    A_RSVD   = 2'd3
  } reg_addr_t;

  localparam int EN_BIT = 0;
  localparam int IM_BIT = 3;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [31:0]         r_preset;
  logic [31:0]         r_count;
  logic                r_irq_flag;

  logic                w_en;
  logic                w_im;
  logic                w_auto_reload;
  logic                w_ctrl_wr;
  logic                w_preset_wr;
  logic                w_cnt_above_one;

  logic                w_load;
  logic                w_dec;
  logic                w_expire;
  logic                w_clr_en;
  logic                w_clr_flag_reload;

  assign w_en            = r_ctrl[EN_BIT];
  assign w_im            = r_ctrl[IM_BIT];
  // MODE 1x falls back to one-shot, so only the exact 01 encoding reloads.
  assign w_auto_reload   = (r_ctrl[2:1] == 2'b01);
  assign w_ctrl_wr       = bus.we && (reg_addr_t'(bus.addr) == A_CTRL);
  assign w_preset_wr     = bus.we && (reg_addr_t'(bus.addr) == A_PRESET);
  assign w_cnt_above_one = (r_count > 32'd1);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output receives a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_en) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_CNT;
      S_CNT: begin
        if (!w_en)                w_state_nxt = S_IDLE;
        else if (!w_cnt_above_one) w_state_nxt = S_INT;
      end
      S_INT:  w_state_nxt = w_auto_reload ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load            = 1'b0;
    w_dec             = 1'b0;
    w_expire          = 1'b0;
    w_clr_en          = 1'b0;
    w_clr_flag_reload = 1'b0;
    unique case (r_state)
      S_LOAD: w_load = 1'b1;
      S_CNT: begin
        w_dec    = w_en &&  w_cnt_above_one;
        w_expire = w_en && !w_cnt_above_one;
      end
      S_INT: begin
        w_clr_en          = !w_auto_reload;
        w_clr_flag_reload =  w_auto_reload;
      end
      default: ;
    endcase
  end

  // A CPU write to CTRL overrides the FSM's one-shot EN clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
    end else if (w_ctrl_wr) begin
      r_ctrl <= bus.wdata[CTRL_W-1:0];
    end else if (w_clr_en) begin
      r_ctrl[EN_BIT] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_preset <= '0;
    end else if (w_preset_wr) begin
      r_preset <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= r_preset;
    end else if (w_dec) begin
      r_count <= r_count - 32'd1;
    end else if (w_expire) begin
      r_count <= '0;
    end
  end

  // Setting the flag wins over a simultaneous CTRL-write clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_flag <= 1'b0;
    end else if (w_expire) begin
      r_irq_flag <= 1'b1;
    end else if (w_ctrl_wr || w_clr_flag_reload) begin
      r_irq_flag <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = '0;
    unique case (reg_addr_t'(bus.addr))
      A_CTRL:   bus.rdata = 32'(r_ctrl);
      A_PRESET: bus.rdata = r_preset;
      A_COUNT:  bus.rdata = r_count;
      A_RSVD:   bus.rdata = '0;
      default:  bus.rdata = '0;
    endcase
  end

  assign bus.irq = w_im & r_irq_flag;

endmodule : timer_counter

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: one-shot, auto-reload, mask/disable,
// edge cases, CTRL/INT collision and asynchronous reset.
`timescale 1ns/1ps

module tb_timer_counter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  timer_counter_if bus ();

  timer_counter #(.CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle write; the write lands on the edge inside this task.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.we    = 1'b1;
    bus.wdata = d;
    step();
    bus.we    = 1'b0;
    bus.wdata = '0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    check(tag, bus.rdata, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    #1;
    check(tag, 32'(bus.irq), 32'(exp));
  endtask

  logic [31:0] ar_cnt [5];
  logic        ar_irq [5];

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    ar_cnt    = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    ar_irq    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    #1;
    chk_rd("rst_ctrl", 2'd0, 32'h0);
    chk_rd("rst_preset", 2'd1, 32'h0);
    chk_rd("rst_count", 2'd2, 32'h0);
    chk_irq("rst_irq", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // One-shot, PRESET=5, CTRL=0x9 at edge k
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step();                                   // k+1
    step();                                   // k+2
    chk_rd("os_count_k2", 2'd2, 32'd5);
    step(); step(); step(); step();           // k+6
    chk_rd("os_count_k6", 2'd2, 32'd1);
    chk_irq("os_irq_k6", 1'b0);
    step();                                   // k+7
    chk_irq("os_irq_k7", 1'b1);
    chk_rd("os_count_k7", 2'd2, 32'd0);
    step();                                   // k+8
    chk_rd("os_ctrl_k8", 2'd0, 32'h8);
    chk_irq("os_irq_k8", 1'b1);
    step();
    chk_irq("os_irq_hold", 1'b1);
    wr(2'd0, 32'h8);
    chk_irq("os_irq_cleared", 1'b0);
    chk_rd("os_ctrl_after_clr", 2'd0, 32'h8);

    // Auto-reload, PRESET=3, CTRL=0xB: 4 periods of 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    step();                                   // LOAD
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 5; c++) begin
        step();
        chk_rd($sformatf("ar_count_p%0d_c%0d", p, c), 2'd2, ar_cnt[c]);
        check($sformatf("ar_irq_p%0d_c%0d", p, c), 32'(bus.irq), 32'(ar_irq[c]));
      end
    end

    // PRESET write mid-run only affects the next reload
    step();
    chk_rd("pw_count_3", 2'd2, 32'd3);
    wr(2'd1, 32'd9);
    chk_rd("pw_count_2", 2'd2, 32'd2);
    step(); step();
    chk_rd("pw_count_0", 2'd2, 32'd0);
    chk_irq("pw_irq", 1'b1);
    step(); step();
    chk_rd("pw_reload_9", 2'd2, 32'd9);
    step();
    chk_rd("pw_count_8", 2'd2, 32'd8);
    wr(2'd0, 32'h0);
    chk_rd("pw_dis_count", 2'd2, 32'd7);
    step();
    chk_rd("pw_frozen", 2'd2, 32'd7);

    // Masked run: CTRL=0x1, PRESET=2
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    step(); step();
    chk_rd("mk_count_2", 2'd2, 32'd2);
    chk_irq("mk_irq_a", 1'b0);
    step();
    chk_irq("mk_irq_b", 1'b0);
    step();
    chk_rd("mk_count_0", 2'd2, 32'd0);
    chk_irq("mk_irq_c", 1'b0);
    step();
    chk_rd("mk_ctrl_en_off", 2'd0, 32'h0);
    chk_irq("mk_irq_d", 1'b0);

    // Disable exactly as COUNT reaches 1
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    step(); step(); step(); step();           // COUNT = 2
    chk_rd("dis_count_2", 2'd2, 32'd2);
    wr(2'd0, 32'h0);
    chk_rd("dis_count_1", 2'd2, 32'd1);
    step();
    chk_rd("dis_frozen_a", 2'd2, 32'd1);
    chk_irq("dis_irq", 1'b0);
    step();
    chk_rd("dis_frozen_b", 2'd2, 32'd1);
    wr(2'd0, 32'h9);                          // re-enable at edge m
    step();
    chk_rd("reen_load_cycle", 2'd2, 32'd1);
    step();
    chk_rd("reen_reloaded", 2'd2, 32'd4);
    step(); step(); step();
    chk_rd("col_count_1", 2'd2, 32'd1);

    // Collision: CTRL=0x9 written on the INT-entry edge and the INT edge
    bus.addr  = 2'd0;
    bus.wdata = 32'h9;
    bus.we    = 1'b1;
    step();
    chk_irq("col_flag_set", 1'b1);
    check("col_ctrl_int", bus.rdata, 32'h9);
    step();
    check("col_ctrl_cpu_wins", bus.rdata, 32'h9);
    chk_irq("col_flag_cleared", 1'b0);
    bus.we    = 1'b0;
    bus.wdata = '0;
    step();
    chk_rd("col_load_cycle", 2'd2, 32'd0);
    step();
    chk_rd("col_reloaded", 2'd2, 32'd4);
    wr(2'd0, 32'h0);
    step();

    // PRESET=0: INT three edges after the EN write
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step();
    chk_irq("p0_irq_k1", 1'b0);
    step();
    chk_irq("p0_irq_k2", 1'b0);
    chk_rd("p0_count_k2", 2'd2, 32'd0);
    step();
    chk_irq("p0_irq_k3", 1'b1);
    step();
    chk_rd("p0_ctrl_k4", 2'd0, 32'h8);

    // COUNT is read-only; reserved address reads 0
    wr(2'd2, 32'hFFFF);
    chk_rd("cnt_wr_ignored", 2'd2, 32'd0);
    wr(2'd3, 32'hDEAD);
    chk_rd("rsvd_read", 2'd3, 32'h0);
    chk_rd("preset_intact", 2'd1, 32'd0);

    // Asynchronous reset mid-count
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(); step(); step();
    chk_rd("rm_count_4", 2'd2, 32'd4);
    rst_n = 1'b0;
    chk_rd("rm_count", 2'd2, 32'h0);
    chk_rd("rm_ctrl", 2'd0, 32'h0);
    chk_rd("rm_preset", 2'd1, 32'h0);
    chk_irq("rm_irq", 1'b0);
    step();
    rst_n = 1'b1;
    step(); step();
    chk_rd("rm_after_release", 2'd2, 32'h0);
    chk_irq("rm_irq_after", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_timer_counter
